// File: rtl/axis_video_src_gen.sv
// AXI4-Stream video test-pattern source.
// Emits frames of cfg_width x cfg_height beats while enable is held, with
// tdata = {zeros, y[7:0], x[7:0], frame_cnt[7:0]}, tuser on pixel (0,0) and
// tlast on the last pixel of each line. Every output is registered.
// Optional feature: define VIDGEN_LINE_GAP_EN to insert LINE_GAP idle cycles
// between lines of a frame (never between frames). DIM_W must be at least 8.
module axis_video_src_gen #(
   parameter int DATA_W   = 24,
   parameter int DIM_W    = 12,
   parameter int LINE_GAP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tuser,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              frame_done
);

   // Reject parameter values the pixel packing cannot represent.
   if (DATA_W < 24 || DIM_W < 8 || LINE_GAP < 0) begin : g_param_check
      $error("axis_video_src_gen: illegal parameter value");
   end

`ifdef VIDGEN_LINE_GAP_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   localparam int GAP_CNT_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

   logic [GAP_CNT_W-1:0] gap_cnt;
   logic [GAP_CNT_W-1:0] gap_cnt_nxt;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1
   } state_t;
`endif

   state_t            state;
   state_t            state_nxt;
   logic [DIM_W-1:0]  x;
   logic [DIM_W-1:0]  x_nxt;
   logic [DIM_W-1:0]  y;
   logic [DIM_W-1:0]  y_nxt;
   logic [DIM_W-1:0]  w;
   logic [DIM_W-1:0]  w_nxt;
   logic [DIM_W-1:0]  h;
   logic [DIM_W-1:0]  h_nxt;
   logic [7:0]        frame_cnt;
   logic [7:0]        frame_cnt_nxt;
   logic              done_nxt;
   logic              cfg_ok;
   logic              handshake;
   logic [DATA_W-1:0] tdata_nxt;

   assign cfg_ok    = (cfg_width != '0) && (cfg_height != '0);
   assign handshake = m_axis_tvalid && m_axis_tready;

   // State and position registers; reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         w         <= '0;
         h         <= '0;
         frame_cnt <= '0;
`ifdef VIDGEN_LINE_GAP_EN
         gap_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         w         <= w_nxt;
         h         <= h_nxt;
         frame_cnt <= frame_cnt_nxt;
`ifdef VIDGEN_LINE_GAP_EN
         gap_cnt   <= gap_cnt_nxt;
`endif
      end
   end

   // Next-state logic: start on enable, advance the raster on each handshake.
   always_comb begin
      state_nxt     = state;
      x_nxt         = x;
      y_nxt         = y;
      w_nxt         = w;
      h_nxt         = h;
      frame_cnt_nxt = frame_cnt;
      done_nxt      = 1'b0;
`ifdef VIDGEN_LINE_GAP_EN
      gap_cnt_nxt   = gap_cnt;
`endif
      case (state)
         IDLE: begin
            x_nxt = '0;
            y_nxt = '0;
            if (enable && cfg_ok) begin
               state_nxt = ACTIVE;
               w_nxt     = cfg_width;
               h_nxt     = cfg_height;
            end
         end
         ACTIVE: begin
            if (handshake) begin
               if (x < w - DIM_W'(1)) begin
                  x_nxt = x + DIM_W'(1);
               end else if (y < h - DIM_W'(1)) begin
                  x_nxt = '0;
                  y_nxt = y + DIM_W'(1);
`ifdef VIDGEN_LINE_GAP_EN
                  if (LINE_GAP > 0) begin
                     state_nxt   = GAP;
                     gap_cnt_nxt = GAP_CNT_W'(LINE_GAP - 1);
                  end
`endif
               end else begin
                  x_nxt         = '0;
                  y_nxt         = '0;
                  done_nxt      = 1'b1;
                  frame_cnt_nxt = frame_cnt + 8'd1;
                  if (enable && cfg_ok) begin
                     w_nxt = cfg_width;
                     h_nxt = cfg_height;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
`ifdef VIDGEN_LINE_GAP_EN
         GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = ACTIVE;
            end else begin
               gap_cnt_nxt = gap_cnt - GAP_CNT_W'(1);
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Pixel word for the beat that will be presented after the next edge.
   always_comb begin
      tdata_nxt        = '0;
      tdata_nxt[23:0]  = {y_nxt[7:0], x_nxt[7:0], frame_cnt_nxt};
   end

   // Registered outputs, derived from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         m_axis_tdata  <= tdata_nxt;
         m_axis_tvalid <= (state_nxt == ACTIVE);
         m_axis_tuser  <= (state_nxt == ACTIVE) && (x_nxt == '0) && (y_nxt == '0);
         m_axis_tlast  <= (state_nxt == ACTIVE) && (x_nxt == w_nxt - DIM_W'(1));
         busy          <= (state_nxt != IDLE);
         frame_done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_axis_video_src_gen.sv
// Directed testbench for axis_video_src_gen.
// Inputs change 1 time unit after each rising edge, which is also when outputs
// are sampled. The gap scenario runs only when VIDGEN_LINE_GAP_EN is defined.
module tb_axis_video_src_gen;

   localparam int DATA_W = 24;
   localparam int DIM_W  = 12;

   logic              clk;
   logic              rst;
   logic              enable;
   logic [DIM_W-1:0]  cfg_width;
   logic [DIM_W-1:0]  cfg_height;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tuser;
   logic              m_axis_tlast;
   logic              busy;
   logic              frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_count = 0;

   axis_video_src_gen #(
      .DATA_W   (DATA_W),
      .DIM_W    (DIM_W),
      .LINE_GAP (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .cfg_width     (cfg_width),
      .cfg_height    (cfg_height),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic en, input logic [DIM_W-1:0] w,
                                input logic [DIM_W-1:0] h, input logic rdy);
      enable        = en;
      cfg_width     = w;
      cfg_height    = h;
      m_axis_tready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance one cycle, counting a handshake if one is about to be taken.
   task automatic tickCount();
      if (m_axis_tvalid && m_axis_tready) hs_count++;
      tick();
   endtask

   task automatic checkBeat(input string tag, input logic [23:0] data,
                            input logic user, input logic last);
      checkOutput({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'd1);
      checkOutput({tag, ".tdata"},  32'(m_axis_tdata),  32'(data));
      checkOutput({tag, ".tuser"},  32'(m_axis_tuser),  32'(user));
      checkOutput({tag, ".tlast"},  32'(m_axis_tlast),  32'(last));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".tdata"},      32'(m_axis_tdata),  32'd0);
      checkOutput({tag, ".tvalid"},     32'(m_axis_tvalid), 32'd0);
      checkOutput({tag, ".tuser"},      32'(m_axis_tuser),  32'd0);
      checkOutput({tag, ".tlast"},      32'(m_axis_tlast),  32'd0);
      checkOutput({tag, ".busy"},       32'(busy),          32'd0);
      checkOutput({tag, ".frame_done"}, 32'(frame_done),    32'd0);
   endtask

   // Expected beats for a 4x2 frame followed by the first beat of the next.
   logic [23:0] exp_data [9] = '{24'h000000, 24'h000100, 24'h000200, 24'h000300,
                                 24'h010000, 24'h010100, 24'h010200, 24'h010300,
                                 24'h000001};
   logic        exp_user [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        exp_last [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic        exp_done [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // Directed sequence.
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 12'd0, 12'd0, 1'b0);
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();

      // 4x2 frames back to back, tready held high.
      applyStimulus(1'b1, 12'd4, 12'd2, 1'b1);
      tick();
      for (int b = 0; b < 9; b++) begin
         checkBeat($sformatf("raster.beat%0d", b + 1), exp_data[b], exp_user[b], exp_last[b]);
         checkOutput($sformatf("raster.done%0d", b + 1), 32'(frame_done), 32'(exp_done[b]));
         if (b == 8) enable = 1'b0;
         tick();
      end
      // Second frame was already started on beat 9; it drains 7 more beats.
      for (int b = 0; b < 7; b++) tick();
      checkOutput("drain.tvalid",     32'(m_axis_tvalid), 32'd0);
      checkOutput("drain.busy",       32'(busy),          32'd0);
      checkOutput("drain.frame_done", 32'(frame_done),    32'd1);
      checkOutput("drain.tdata",      32'(m_axis_tdata),  32'h000002);
      tick();
      checkOutput("drain.done_pulse", 32'(frame_done),    32'd0);

      // Backpressure: 3x1 frame with tready 1,0,0,1 then 1.
      applyStimulus(1'b1, 12'd3, 12'd1, 1'b1);
      hs_count = 0;
      tick();
      checkBeat("bp.A", 24'h000002, 1'b1, 1'b0);
      enable = 1'b0;
      m_axis_tready = 1'b1;
      tickCount();
      checkBeat("bp.B", 24'h000102, 1'b0, 1'b0);
      m_axis_tready = 1'b0;
      tickCount();
      checkBeat("bp.C", 24'h000102, 1'b0, 1'b0);
      m_axis_tready = 1'b0;
      tickCount();
      checkBeat("bp.D", 24'h000102, 1'b0, 1'b0);
      m_axis_tready = 1'b1;
      tickCount();
      checkBeat("bp.E", 24'h000202, 1'b0, 1'b1);
      tickCount();
      checkOutput("bp.end_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("bp.frame_done", 32'(frame_done),    32'd1);
      for (int i = 0; i < 4; i++) tickCount();
      checkOutput("bp.handshakes", 32'(hs_count), 32'd3);

      // Enable dropped mid-frame, cfg changed mid-frame: 2x2 still completes.
      applyStimulus(1'b1, 12'd2, 12'd2, 1'b1);
      tick();
      checkBeat("en.beat1", 24'h000003, 1'b1, 1'b0);
      cfg_width  = 12'd7;
      cfg_height = 12'd7;
      tick();
      checkBeat("en.beat2", 24'h000103, 1'b0, 1'b1);
      enable = 1'b0;
      tick();
      checkBeat("en.beat3", 24'h010003, 1'b0, 1'b0);
      tick();
      checkBeat("en.beat4", 24'h010103, 1'b0, 1'b1);
      tick();
      checkOutput("en.idle_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("en.idle_busy",   32'(busy),          32'd0);
      checkOutput("en.state",       32'(dut.state),     32'd0);

      // Zero width: enable is ignored.
      applyStimulus(1'b1, 12'd0, 12'd5, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput($sformatf("zero.tvalid%0d", i), 32'(m_axis_tvalid), 32'd0);
         checkOutput($sformatf("zero.busy%0d", i),   32'(busy),          32'd0);
      end

      // Reset on beat 3 of a 4-wide frame, then restart.
      applyStimulus(1'b1, 12'd4, 12'd2, 1'b1);
      tick();
      checkBeat("rst.beat1", 24'h000004, 1'b1, 1'b0);
      tick();
      checkBeat("rst.beat2", 24'h000104, 1'b0, 1'b0);
      tick();
      checkBeat("rst.beat3", 24'h000204, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      checkAllZero("rst.after");
      rst = 1'b0;
      tick();
      checkBeat("rst.restart", 24'h000000, 1'b1, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("rst.drain_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("rst.drain_busy",   32'(busy),          32'd0);

      // 1x1 frames: every beat is both start of frame and end of line.
      applyStimulus(1'b1, 12'd1, 12'd1, 1'b1);
      tick();
      checkBeat("one.beat1", 24'h000001, 1'b1, 1'b1);
      tick();
      checkBeat("one.beat2", 24'h000002, 1'b1, 1'b1);
      checkOutput("one.frame_done", 32'(frame_done), 32'd1);
      enable = 1'b0;
      tick();
      checkOutput("one.idle_tvalid", 32'(m_axis_tvalid), 32'd0);

`ifdef VIDGEN_LINE_GAP_EN
      // Line gap: 4 idle cycles between lines, none between frames.
      applyStimulus(1'b1, 12'd2, 12'd2, 1'b1);
      tick();
      checkBeat("gap.beat1", 24'h000003, 1'b1, 1'b0);
      tick();
      checkBeat("gap.beat2", 24'h000103, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("gap.idle%0d", i), 32'(m_axis_tvalid), 32'd0);
         checkOutput($sformatf("gap.busy%0d", i), 32'(busy),          32'd1);
      end
      tick();
      checkBeat("gap.beat3", 24'h010003, 1'b0, 1'b0);
      tick();
      checkBeat("gap.beat4", 24'h010103, 1'b0, 1'b1);
      tick();
      checkBeat("gap.next_frame", 24'h000004, 1'b1, 1'b0);
      enable = 1'b0;
      begin
         int waited;
         waited = 0;
         while ((m_axis_tvalid || busy) && waited < 30) begin
            tick();
            waited++;
         end
         checkOutput("gap.drain", 32'(busy), 32'd0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
